fire_guard: RTL and testbench

- Downstream stage of the protection detector: consumes protect_en/protect_state and gates raw trigger pulses before they reach the MOSFET gate drivers.
- Enforces P/N dead time and suppresses truncated pulses.
- Latches a fault snapshot; runs a hold-off/retry policy; hard-locks after repeated trips until host clear.

---
 rtl/fire_guard_pkg.sv | 25 ++
 rtl/fire_guard_if.sv | 29 ++
 rtl/fire_deadtime.sv | 27 ++
 rtl/fire_guard.sv | 179 +++++++++++++++++
 tb/tb_fire_guard.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fire_guard_pkg.sv
// Shared types and constants for the fire_guard gate-drive protection slice.
package fire_guard_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_TRIP    = 3'd2,
        ST_HOLDOFF = 3'd3,
        ST_LOCK    = 3'd4
    } fgState_t;

    localparam int FAULT_W         = 6;
    localparam int FCNT_W          = 8;
    localparam int HOLDOFF_CYC_DEF = 3000;
    localparam int MAX_RETRY_DEF   = 4;
    localparam int MIN_GAP_DEF     = 4;

    // Timer never narrower than 16 bits so firmware-visible tuning stays uniform.
    function automatic int timerWidth(input int cyc);
        int w;
        w = $clog2(cyc + 1);
        return (w < 16) ? 16 : w;
    endfunction

endpackage

// File: rtl/fire_guard_if.sv
// Host/detector-facing signal bundle of fire_guard.
interface fire_guard_if;
    import fire_guard_pkg::*;

    logic               trig_p_in;
    logic               trig_n_in;
    logic               protect_en;
    logic [FAULT_W-1:0] protect_state;
    logic               arm;
    logic               fault_clr;
    logic               drv_p;
    logic               drv_n;
    logic [FAULT_W-1:0] fault_latched;
    logic [FCNT_W-1:0]  fault_cnt;
    logic               overlap_err;
    logic               locked;
    logic [2:0]         state_o;

    modport master (
        output trig_p_in, trig_n_in, protect_en, protect_state, arm, fault_clr,
        input  drv_p, drv_n, fault_latched, fault_cnt, overlap_err, locked, state_o
    );

    modport slave (
        input  trig_p_in, trig_n_in, protect_en, protect_state, arm, fault_clr,
        output drv_p, drv_n, fault_latched, fault_cnt, overlap_err, locked, state_o
    );

endinterface

// File: rtl/fire_deadtime.sv
// Per-channel dead-time tracker: reports when the opposite driver has been idle long enough.
module fire_deadtime #(
    parameter int MIN_GAP = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic drv_other,
    output logic gap_ok
);

    localparam int CNT_W = $clog2(MIN_GAP + 1);

    logic [CNT_W-1:0] lowCnt;

    always_ff @(posedge clk) begin
        if (reset || clr || drv_other) begin
            lowCnt <= '0;
        end else if (lowCnt != CNT_W'(MIN_GAP)) begin
            lowCnt <= lowCnt + 1'b1;
        end
    end

    // The cycle in progress counts as idle, so the opposite side may rise after exactly MIN_GAP idle cycles.
    assign gap_ok = !drv_other && (lowCnt >= CNT_W'(MIN_GAP - 1));

endmodule

// File: rtl/fire_guard.sv
// Gates raw P/N triggers to the gate drivers with dead time, trip handling, retry hold-off and lockout.
// state   | meaning
// IDLE    | disarmed, drivers off
// RUN     | armed; pulses pass once both triggers seen low (quiet)
// TRIP    | protect request active, drivers off
// HOLDOFF | waiting HOLDOFF_CYC clean cycles before re-arming
// LOCK    | too many trips; only fault_clr leaves
module fire_guard
    import fire_guard_pkg::*;
#(
    parameter int HOLDOFF_CYC = HOLDOFF_CYC_DEF,
    parameter int MAX_RETRY   = MAX_RETRY_DEF,
    parameter int MIN_GAP     = MIN_GAP_DEF
) (
    input  logic         clk,
    input  logic         reset,
    fire_guard_if.slave  bus
);

    localparam int TIMER_W = timerWidth(HOLDOFF_CYC);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    fgState_t             state;
    fgState_t             stateNext;
    logic                 quiet;
    logic                 quietNext;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timerNext;
    logic [RETRY_W-1:0]   retryCnt;
    logic [RETRY_W-1:0]   retryNext;
    logic [FCNT_W-1:0]    faultCnt;
    logic [FCNT_W-1:0]    faultCntNext;
    logic [FAULT_W-1:0]   faultLatched;
    logic [FAULT_W-1:0]   faultLatchedNext;
    logic                 faultValid;
    logic                 faultValidNext;
    logic                 overlapErr;
    logic                 overlapNext;
    logic                 drvP;
    logic                 drvN;
    logic                 drvPNext;
    logic                 drvNNext;
    logic                 tripHit;
    logic                 runStay;
    logic                 enterRun;
    logic                 enterHold;
    logic                 retryClr;
    logic                 gapOkP;
    logic                 gapOkN;
    logic                 gapClr;

    assign tripHit = bus.protect_en && (state == ST_RUN || state == ST_HOLDOFF);
    assign gapClr  = (state != ST_RUN);

    fire_deadtime #(.MIN_GAP(MIN_GAP)) u_deadP (
        .clk       (clk),
        .reset     (reset),
        .clr       (gapClr),
        .drv_other (drvN),
        .gap_ok    (gapOkP)
    );

    fire_deadtime #(.MIN_GAP(MIN_GAP)) u_deadN (
        .clk       (clk),
        .reset     (reset),
        .clr       (gapClr),
        .drv_other (drvP),
        .gap_ok    (gapOkN)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            quiet        <= 1'b0;
            timer        <= '0;
            retryCnt     <= '0;
            faultCnt     <= '0;
            faultLatched <= '0;
            faultValid   <= 1'b0;
            overlapErr   <= 1'b0;
            drvP         <= 1'b0;
            drvN         <= 1'b0;
        end else begin
            state        <= stateNext;
            quiet        <= quietNext;
            timer        <= timerNext;
            retryCnt     <= retryNext;
            faultCnt     <= faultCntNext;
            faultLatched <= faultLatchedNext;
            faultValid   <= faultValidNext;
            overlapErr   <= overlapNext;
            drvP         <= drvPNext;
            drvN         <= drvNNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (bus.fault_clr && state == ST_LOCK) begin
            stateNext = ST_IDLE;
        end else if (tripHit) begin
            stateNext = ST_TRIP;
        end else if (!bus.arm && (state inside {ST_RUN, ST_TRIP, ST_HOLDOFF})) begin
            stateNext = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (bus.arm) stateNext = ST_RUN;
                ST_RUN:     stateNext = ST_RUN;
                ST_TRIP:    if (!bus.protect_en)
                                stateNext = (retryCnt >= RETRY_W'(MAX_RETRY)) ? ST_LOCK : ST_HOLDOFF;
                ST_HOLDOFF: if (timer == '0) stateNext = ST_RUN;
                ST_LOCK:    stateNext = ST_LOCK;
                default:    stateNext = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        runStay   = (state == ST_RUN) && (stateNext == ST_RUN);
        enterRun  = (stateNext == ST_RUN) && (state != ST_RUN);
        enterHold = (stateNext == ST_HOLDOFF) && (state != ST_HOLDOFF);

        drvPNext = runStay && quiet && bus.trig_p_in && !bus.trig_n_in && !bus.protect_en && gapOkP;
        drvNNext = runStay && quiet && bus.trig_n_in && !bus.trig_p_in && !bus.protect_en && gapOkN;

        // A pulse already in flight at RUN entry must be let go before anything is driven.
        quietNext = quiet;
        if (enterRun) begin
            quietNext = 1'b0;
        end else if (state == ST_RUN && !bus.trig_p_in && !bus.trig_n_in) begin
            quietNext = 1'b1;
        end

        // One down-counter serves both the hold-off delay and the clean-RUN retry window.
        timerNext = timer;
        retryClr  = 1'b0;
        if (enterRun) begin
            timerNext = TIMER_W'(HOLDOFF_CYC);
        end else if (enterHold) begin
            timerNext = TIMER_W'(HOLDOFF_CYC - 1);
        end else if (state == ST_HOLDOFF) begin
            if (timer != '0) timerNext = timer - 1'b1;
        end else if (runStay && quiet && timer != '0) begin
            timerNext = timer - 1'b1;
            retryClr  = (timer == TIMER_W'(1));
        end

        retryNext = retryCnt;
        if (bus.fault_clr || retryClr) retryNext = '0;
        if (tripHit && retryNext < RETRY_W'(MAX_RETRY)) retryNext = retryNext + 1'b1;

        faultCntNext = faultCnt;
        if (tripHit && faultCnt != '1) faultCntNext = faultCnt + 1'b1;

        faultLatchedNext = faultLatched;
        faultValidNext   = faultValid;
        if (bus.fault_clr) begin
            faultLatchedNext = '0;
            faultValidNext   = 1'b0;
        end
        if (tripHit && !faultValidNext) begin
            faultLatchedNext = bus.protect_state;
            faultValidNext   = 1'b1;
        end

        overlapNext = overlapErr;
        if (state == ST_RUN && bus.trig_p_in && bus.trig_n_in) overlapNext = 1'b1;
        if (bus.fault_clr) overlapNext = 1'b0;
    end

    assign bus.drv_p         = drvP;
    assign bus.drv_n         = drvN;
    assign bus.fault_latched = faultLatched;
    assign bus.fault_cnt     = faultCnt;
    assign bus.overlap_err   = overlapErr;
    assign bus.locked        = (state == ST_LOCK);
    assign bus.state_o       = state;

endmodule

// File: tb/tb_fire_guard.sv
// Bench for fire_guard: directed vector table, multi-cycle corner sequences, randomized run against a timestamp model.
module tb_fire_guard;

    localparam int HC = 20;
    localparam int MR = 3;
    localparam int MG = 4;

    logic clk = 1'b0;
    logic reset;
    fire_guard_if bus();

    fire_guard #(.HOLDOFF_CYC(HC), .MAX_RETRY(MR), .MIN_GAP(MG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    typedef struct {
        bit       arm;
        bit       tp;
        bit       tn;
        bit       clr;
        bit       dp;
        bit       dn;
        bit [2:0] st;
        bit       ov;
    } vec_t;

    vec_t tbl[$];

    // Reference model: spec-level view using edge timestamps instead of counters.
    bit         modelOn = 1'b0;
    int         cyc = 0;
    int         mState, mRetry, mFcnt, mLastP, mLastN, mHoldEntry, mClean;
    bit         mQuiet, mDrvP, mDrvN, mOverlap, mValid;
    logic [5:0] mLatched;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t v(input bit arm, input bit tp, input bit tn, input bit clr,
                               input bit dp, input bit dn, input int st, input bit ov);
        vec_t r;
        r.arm = arm; r.tp = tp; r.tn = tn; r.clr = clr;
        r.dp = dp; r.dn = dn; r.st = 3'(st); r.ov = ov;
        return r;
    endfunction

    task automatic modelReset();
        mState = 0; mRetry = 0; mFcnt = 0; mClean = 0; mHoldEntry = 0;
        mLastP = 0; mLastN = 0;
        mQuiet = 0; mDrvP = 0; mDrvN = 0; mOverlap = 0; mValid = 0; mLatched = '0;
    endtask

    task automatic modelStep();
        int ns;
        bit trip, tp, tn, pe, nP, nN;
        tp = bus.trig_p_in; tn = bus.trig_n_in; pe = bus.protect_en;
        cyc++;
        if (reset) begin
            modelReset();
            return;
        end
        trip = pe && (mState == 1 || mState == 3);
        if (bus.fault_clr && mState == 4) ns = 0;
        else if (trip) ns = 2;
        else if (!bus.arm && (mState == 1 || mState == 2 || mState == 3)) ns = 0;
        else begin
            case (mState)
                0:       ns = bus.arm ? 1 : 0;
                2:       ns = pe ? 2 : ((mRetry >= MR) ? 4 : 3);
                3:       ns = (cyc - mHoldEntry >= HC) ? 1 : 3;
                default: ns = mState;
            endcase
        end
        nP = 0; nN = 0;
        if (mState == 1 && ns == 1 && mQuiet) begin
            nP = tp && !tn && (cyc - 1 - mLastN >= MG);
            nN = tn && !tp && (cyc - 1 - mLastP >= MG);
            mClean++;
            if (mClean == HC) mRetry = 0;
        end
        if (mState == 1 && tp && tn) mOverlap = 1;
        if (bus.fault_clr) begin
            mOverlap = 0; mRetry = 0; mValid = 0; mLatched = '0;
        end
        if (trip) begin
            if (mFcnt < 255) mFcnt++;
            if (mRetry < MR) mRetry++;
            if (!mValid) begin
                mLatched = bus.protect_state;
                mValid = 1;
            end
        end
        if (ns == 1 && mState != 1) begin
            mQuiet = 0; mClean = 0; mLastP = cyc - 1; mLastN = cyc - 1;
        end else if (mState == 1 && !tp && !tn) begin
            mQuiet = 1;
        end
        if (ns == 3 && mState != 3) mHoldEntry = cyc;
        mState = ns;
        mDrvP = nP;
        mDrvN = nN;
        if (nP) mLastP = cyc;
        if (nN) mLastN = cyc;
    endtask

    task automatic step();
        @(posedge clk);
        if (modelOn) modelStep();
        @(negedge clk);
    endtask

    task automatic setIn(input bit arm, input bit tp, input bit tn, input bit pe, input bit clr);
        bus.arm = arm; bus.trig_p_in = tp; bus.trig_n_in = tn;
        bus.protect_en = pe; bus.fault_clr = clr;
    endtask

    task automatic doReset();
        setIn(0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic waitState(input logic [2:0] s, input int maxCyc);
        int n;
        n = 0;
        while (bus.state_o != s && n < maxCyc) begin
            step();
            n++;
        end
    endtask

    function automatic logic [20:0] dutVec();
        return {bus.drv_p, bus.drv_n, bus.fault_latched, bus.fault_cnt,
                bus.overlap_err, bus.locked, bus.state_o};
    endfunction

    initial begin
        int n;
        logic [20:0] expV;
        bus.protect_state = '0;
        setIn(0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        check("rst_drv", {bus.drv_p, bus.drv_n}, 2'b00);
        check("rst_state", bus.state_o, 3'd0);
        check("rst_latched", bus.fault_latched, 6'd0);
        check("rst_fcnt", bus.fault_cnt, 8'd0);
        check("rst_flags", {bus.overlap_err, bus.locked}, 2'b00);
        reset = 1'b0;

        // normal pulse
        for (int i = 0; i < 5; i++) tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(v(1, 1, 0, 0, 1, 0, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0));
        // arm rising mid-pulse
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(v(1, 1, 0, 0, 1, 0, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0));
        // dead time
        for (int i = 0; i < 3; i++) tbl.push_back(v(1, 1, 0, 0, 1, 0, 1, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(v(1, 0, 1, 0, 0, 0, 1, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(v(1, 0, 1, 0, 0, 1, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0));
        // overlap
        tbl.push_back(v(1, 1, 1, 0, 0, 0, 1, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            setIn(tbl[i].arm, tbl[i].tp, tbl[i].tn, 0, tbl[i].clr);
            step();
            check($sformatf("vec%0d", i),
                  {bus.drv_p, bus.drv_n, bus.state_o, bus.overlap_err, bus.fault_cnt},
                  {tbl[i].dp, tbl[i].dn, tbl[i].st, tbl[i].ov, 8'd0});
        end

        // trip and recovery
        setIn(1, 1, 0, 0, 0);
        step();
        check("pre_trip_drv_p", bus.drv_p, 1'b1);
        bus.protect_state = 6'b000101;
        bus.protect_en = 1'b1;
        step();
        check("trip_drv_p", bus.drv_p, 1'b0);
        check("trip_state", bus.state_o, 3'd2);
        check("trip_latched", bus.fault_latched, 6'b000101);
        check("trip_fcnt", bus.fault_cnt, 8'd1);
        setIn(1, 0, 0, 0, 0);
        bus.protect_state = 6'b111000;
        step();
        check("holdoff_state", bus.state_o, 3'd3);
        n = 1;
        for (int j = 0; j < 100; j++) begin
            step();
            if (bus.state_o != 3'd3) break;
            n++;
        end
        check("holdoff_len", n, HC);
        check("rearm_state", bus.state_o, 3'd1);
        for (int j = 0; j < 4; j++) step();
        bus.trig_p_in = 1'b1;
        step();
        check("post_rearm_drv_p", bus.drv_p, 1'b1);
        check("latched_kept", bus.fault_latched, 6'b000101);
        bus.trig_p_in = 1'b0;
        step();

        // lockout after MR trips inside the clean window
        doReset();
        bus.arm = 1'b1;
        for (int j = 0; j < 5; j++) step();
        bus.protect_state = 6'b110010;
        for (int t = 0; t < MR; t++) begin
            bus.protect_en = 1'b1;
            step();
            check($sformatf("lock_trip%0d", t), bus.state_o, 3'd2);
            bus.protect_en = 1'b0;
            bus.protect_state = 6'b000011;
            step();
        end
        check("lock_state", bus.state_o, 3'd4);
        check("lock_flag", bus.locked, 1'b1);
        check("lock_fcnt", bus.fault_cnt, 8'(MR));
        check("lock_first_fault", bus.fault_latched, 6'b110010);
        for (int j = 0; j < 4; j++) begin
            bus.arm = j[0];
            step();
        end
        check("lock_arm_ignored", bus.state_o, 3'd4);
        bus.fault_clr = 1'b1;
        step();
        bus.fault_clr = 1'b0;
        check("clr_state", bus.state_o, 3'd0);
        check("clr_latched", bus.fault_latched, 6'd0);
        check("clr_fcnt", bus.fault_cnt, 8'(MR));
        check("clr_locked", bus.locked, 1'b0);

        // a clean RUN window forgives earlier trips
        doReset();
        bus.arm = 1'b1;
        for (int j = 0; j < 5; j++) step();
        for (int t = 0; t < 2; t++) begin
            bus.protect_en = 1'b1;
            step();
            bus.protect_en = 1'b0;
            step();
        end
        waitState(3'd1, 100);
        check("window_run", bus.state_o, 3'd1);
        for (int j = 0; j < HC + 5; j++) step();
        bus.protect_en = 1'b1;
        step();
        bus.protect_en = 1'b0;
        step();
        check("window_clear", bus.state_o, 3'd3);

        // reset in the middle of HOLDOFF
        doReset();
        bus.arm = 1'b1;
        for (int j = 0; j < 3; j++) step();
        bus.protect_en = 1'b1;
        step();
        bus.protect_en = 1'b0;
        step();
        for (int j = 0; j < 10; j++) step();
        check("mid_hold_state", bus.state_o, 3'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_hold_rst", dutVec(), 21'd0);

        // randomized run against the model
        modelOn = 1'b1;
        setIn(0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            expV = {mDrvP, mDrvN, mLatched, 8'(mFcnt), mOverlap, (mState == 4), 3'(mState)};
            check($sformatf("rand%0d", k), dutVec(), expV);
            if ($urandom_range(3) == 0) bus.trig_p_in = ~bus.trig_p_in;
            if ($urandom_range(3) == 0) bus.trig_n_in = ~bus.trig_n_in;
            if (bus.protect_en) bus.protect_en = ($urandom_range(9) >= 3);
            else bus.protect_en = ($urandom_range(99) == 0);
            bus.protect_state = 6'($urandom);
            if (bus.arm) bus.arm = ($urandom_range(199) != 0);
            else bus.arm = ($urandom_range(9) == 0);
            bus.fault_clr = (mState == 4) ? ($urandom_range(9) == 0) : ($urandom_range(199) == 0);
            reset = ($urandom_range(999) < 2);
            step();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
